psum_accumulator: RTL and testbench

- Downstream stage of the layer-3 partial-sum adder. Consumes one vector of CHANNEL_NUM signed 8-bit partial sums per valid beat.
- Accumulates ACC_NUM consecutive beats per channel, one per kernel position of a window.
- At the end of each window, per channel: adds a bias, applies ReLU, right-shifts, and saturates to the unsigned 4-bit activation used by the next layer.
- Emits one output vector with a single-cycle valid pulse per completed window.

---
 rtl/psum_acc_pkg.sv | 27 ++
 rtl/psum_requant.sv | 41 ++++
 rtl/psum_accumulator.sv | 117 +++++++++++
 tb/tb_psum_accumulator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg
//   Shared defaults for the partial-sum accumulator: datapath widths, the
//   window length, the activation ceiling and the element typedefs used by
//   psum_accumulator and psum_requant.
package psum_acc_pkg;

  localparam int CHANNEL_NUM_DEF = 128;
  localparam int ACC_NUM_DEF     = 9;
  localparam int IN_WIDTH_DEF    = 8;
  localparam int ACC_WIDTH_DEF   = 12;
  localparam int SHIFT_DEF       = 4;
  localparam int OUT_WIDTH_DEF   = 4;

  // ACC_NUM is limited to 15, so a 4-bit beat counter always suffices.
  localparam int CNT_WIDTH = 4;

  localparam int OUT_MAX = (1 << OUT_WIDTH_DEF) - 1;

  typedef logic signed [IN_WIDTH_DEF-1:0]  psum_t;
  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;
  typedef logic        [OUT_WIDTH_DEF-1:0] act_t;

  function automatic int out_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/psum_requant.sv
// psum_requant
//   Combinational end-of-window requantisation for one channel:
//   bias add, ReLU, arithmetic right shift, unsigned saturation.
// Ports:
//   acc  - accumulated partial sum of the earlier beats (0 on a 1-beat window)
//   data - sign-extended partial sum of the last beat
//   bias - per-channel bias
//   q    - saturated unsigned activation
//   sat  - high when the shifted value exceeded the activation ceiling
module psum_requant
  import psum_acc_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int SHIFT     = SHIFT_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [ACC_WIDTH-1:0] data,
  input  logic signed [ACC_WIDTH-1:0] bias,
  output logic        [OUT_WIDTH-1:0] q,
  output logic                        sat
);

  // One extra bit so acc + data + bias can never wrap.
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [SW-1:0]        MAX_WIDE = SW'(out_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] MAX_OUT  = OUT_WIDTH'(out_max(OUT_WIDTH));

  logic signed [SW-1:0] s;
  logic signed [SW-1:0] shifted;
  logic        [SW-1:0] r;

  always_comb begin
    s       = SW'(acc) + SW'(data) + SW'(bias);
    shifted = s >>> SHIFT;
    r       = s[SW-1] ? '0 : shifted;
    sat     = (r > MAX_WIDE);
    q       = sat ? MAX_OUT : r[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates ACC_NUM beats of per-channel signed partial sums, then
//   requantises each channel (bias, ReLU, shift, saturate) and emits one
//   output vector with a single-cycle valid pulse per completed window.
// Ports:
//   clk, rstn       - clock, asynchronous active-low reset
//   data_in_valid   - one beat of partial sums present on data_in
//   data_in         - per-channel signed partial sums
//   acc_clear       - synchronous abort of the current window (beats dropped)
//   bias            - per-channel bias, sampled on a window's last beat
//   data_out_valid  - one-cycle pulse per completed window
//   data_out        - registered unsigned activations, held between pulses
//   sat_flag        - some channel clipped high in the last window
//   busy            - a window is partially accumulated
//
// beat_cnt | meaning
// ---------+----------------------------------------
// 0        | idle, next beat starts a new window
// 1..N-1   | accumulating, beat_cnt beats absorbed
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int ACC_NUM     = ACC_NUM_DEF,
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int SHIFT       = SHIFT_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        data_in_valid,
  input  logic signed [IN_WIDTH-1:0]  data_in [CHANNEL_NUM],
  input  logic                        acc_clear,
  input  logic signed [ACC_WIDTH-1:0] bias    [CHANNEL_NUM],
  output logic                        data_out_valid,
  output logic        [OUT_WIDTH-1:0] data_out [CHANNEL_NUM],
  output logic                        sat_flag,
  output logic                        busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_NUM - 1);

  logic [CNT_WIDTH-1:0]   beat_cnt;
  logic                   first_beat;
  logic                   last_beat;
  logic                   beat_acc;
  logic                   beat_fin;
  logic [CHANNEL_NUM-1:0] sat_vec;

  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == LAST_CNT);
  assign beat_acc   = data_in_valid && !acc_clear && !last_beat;
  assign beat_fin   = data_in_valid && !acc_clear && last_beat;
  assign busy       = !first_beat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt       <= '0;
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
    end else if (acc_clear) begin
      beat_cnt       <= '0;
      data_out_valid <= 1'b0;
    end else if (beat_fin) begin
      beat_cnt       <= '0;
      data_out_valid <= 1'b1;
      sat_flag       <= |sat_vec;
    end else if (beat_acc) begin
      beat_cnt       <= beat_cnt + CNT_WIDTH'(1);
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] din_ext;
    logic        [OUT_WIDTH-1:0] q;

    // The first beat overwrites rather than adds, so a stale accumulator
    // from an aborted or finished window never leaks into the next one.
    assign din_ext  = ACC_WIDTH'(data_in[g]);
    assign acc_base = first_beat ? '0 : acc;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        acc <= '0;
      end else if (beat_acc) begin
        acc <= acc_base + din_ext;
      end
    end

    psum_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
      .acc  (acc_base),
      .data (din_ext),
      .bias (bias[g]),
      .q    (q),
      .sat  (sat_vec[g])
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        data_out[g] <= '0;
      end else if (beat_fin) begin
        data_out[g] <= q;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
//   Directed bench for psum_accumulator: default 9-beat instance plus a
//   2-channel ACC_NUM=1 instance. Inputs change on the falling edge and
//   outputs are checked on the falling edge.
module tb_psum_accumulator;

  localparam int CH  = 128;
  localparam int CH1 = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              data_in_valid = 1'b0;
  logic              acc_clear = 1'b0;
  logic signed [7:0]  data_in [CH];
  logic signed [11:0] bias    [CH];
  logic              data_out_valid;
  logic        [3:0] data_out [CH];
  logic              sat_flag;
  logic              busy;

  logic              d1_valid = 1'b0;
  logic              d1_clear = 1'b0;
  logic signed [7:0]  d1_data [CH1];
  logic signed [11:0] d1_bias [CH1];
  logic              d1_out_valid;
  logic        [3:0] d1_out [CH1];
  logic              d1_sat;
  logic              d1_busy;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  always @(posedge clk) if (data_out_valid) pulses++;

  psum_accumulator dut (
    .clk            (clk),
    .rstn           (rstn),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .acc_clear      (acc_clear),
    .bias           (bias),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .sat_flag       (sat_flag),
    .busy           (busy)
  );

  psum_accumulator #(.CHANNEL_NUM(CH1), .ACC_NUM(1)) dut1 (
    .clk            (clk),
    .rstn           (rstn),
    .data_in_valid  (d1_valid),
    .data_in        (d1_data),
    .acc_clear      (d1_clear),
    .bias           (d1_bias),
    .data_out_valid (d1_out_valid),
    .data_out       (d1_out),
    .sat_flag       (d1_sat),
    .busy           (d1_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = exp;
    for (int i = 0; i < CH; i++) begin
      if (data_out[i] !== exp) begin
        obs = data_out[i];
        break;
      end
    end
    check(tag, {28'd0, obs}, {28'd0, exp});
  endtask

  task automatic set_data(input logic signed [7:0] v);
    for (int i = 0; i < CH; i++) data_in[i] = v;
  endtask

  task automatic beat(input logic signed [7:0] v);
    @(negedge clk);
    data_in_valid = 1'b1;
    set_data(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      acc_clear = 1'b0;
    end
  endtask

  task automatic finish_window(input string tag, input logic [3:0] exp, input logic exp_sat);
    @(negedge clk);
    data_in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, data_out_valid}, 32'd1);
    check_all({tag, "_data"}, exp);
    check({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_sat});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_data(8'sd0);
    for (int i = 0; i < CH; i++) bias[i] = 12'sd0;
    for (int i = 0; i < CH1; i++) begin
      d1_data[i] = 8'sd0;
      d1_bias[i] = 12'sd20;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check_all("rst_data", 4'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    // Basic window: 9 x 10 = 90, >>>4 = 5
    for (int k = 0; k < 9; k++) begin
      beat(8'sd10);
      if (k == 1) check("basic_busy", {31'd0, busy}, 32'd1);
      if (k == 8) check("basic_early", {31'd0, data_out_valid}, 32'd0);
    end
    finish_window("basic", 4'd5, 1'b0);
    check("basic_busy_end", {31'd0, busy}, 32'd0);
    idle(1);
    check("basic_pulse_width", {31'd0, data_out_valid}, 32'd0);
    check_all("basic_hold", 4'd5);

    // Saturation high: 9 x 127 = 1143 -> 71 -> 15, sat
    repeat (9) beat(8'sd127);
    finish_window("sat_hi", 4'd15, 1'b1);
    idle(2);
    check("sat_hold", {31'd0, sat_flag}, 32'd1);

    // Negative: 9 x -128 = -1152 -> ReLU 0
    repeat (9) beat(-8'sd128);
    finish_window("sat_neg", 4'd0, 1'b0);

    // Bias and ReLU on zero data
    bias[0] = 12'sd16;
    bias[1] = -12'sd16;
    bias[2] = 12'sd47;
    repeat (9) beat(8'sd0);
    @(negedge clk);
    data_in_valid = 1'b0;
    check("bias_valid", {31'd0, data_out_valid}, 32'd1);
    check("bias_ch0", {28'd0, data_out[0]}, 32'd1);
    check("bias_ch1", {28'd0, data_out[1]}, 32'd0);
    check("bias_ch2", {28'd0, data_out[2]}, 32'd2);
    check("bias_ch3", {28'd0, data_out[3]}, 32'd0);
    for (int i = 0; i < 3; i++) bias[i] = 12'sd0;

    // acc_clear with a concurrent (dropped) beat
    idle(1);
    p0 = pulses;
    repeat (4) beat(8'sd50);
    @(negedge clk);
    acc_clear = 1'b1;
    data_in_valid = 1'b1;
    set_data(8'sd50);
    @(negedge clk);
    acc_clear = 1'b0;
    data_in_valid = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_valid", {31'd0, data_out_valid}, 32'd0);
    repeat (9) beat(8'sd2);
    finish_window("clr", 4'd1, 1'b0);
    idle(3);
    check("clr_pulses", pulses, p0 + 1);

    // Gapped window A (9 x 16 = 144 -> 9), back-to-back window B (9 x 32 -> 15)
    for (int k = 0; k < 9; k++) begin
      int gap;
      beat(8'sd16);
      if (k < 8) begin
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          idle(gap);
          check("gap_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
    @(negedge clk);
    data_in_valid = 1'b1;
    set_data(8'sd32);
    check("winA_valid", {31'd0, data_out_valid}, 32'd1);
    check_all("winA_data", 4'd9);
    check("winA_sat", {31'd0, sat_flag}, 32'd0);
    check("winA_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      beat(8'sd32);
      if (k == 3) check("winB_busy", {31'd0, busy}, 32'd1);
    end
    finish_window("winB", 4'd15, 1'b1);

    // Reset mid-window
    repeat (5) beat(8'sd10);
    @(negedge clk);
    data_in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mrst_valid", {31'd0, data_out_valid}, 32'd0);
    check_all("mrst_data", 4'd0);
    check("mrst_sat", {31'd0, sat_flag}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    p0 = pulses;
    repeat (9) beat(8'sd10);
    finish_window("mrst", 4'd5, 1'b0);
    idle(3);
    check("mrst_pulses", pulses, p0 + 1);

    // ACC_NUM = 1: every beat completes a window, no carry between beats
    @(negedge clk);
    d1_valid = 1'b1;
    d1_data[0] = 8'sd100;   // 120 >>> 4 = 7
    d1_data[1] = -8'sd50;   // -30 -> 0
    @(negedge clk);
    d1_data[0] = 8'sd30;    // 50 >>> 4 = 3
    d1_data[1] = 8'sd127;   // 147 >>> 4 = 9
    check("n1_a_valid", {31'd0, d1_out_valid}, 32'd1);
    check("n1_a_ch0", {28'd0, d1_out[0]}, 32'd7);
    check("n1_a_ch1", {28'd0, d1_out[1]}, 32'd0);
    check("n1_busy", {31'd0, d1_busy}, 32'd0);
    @(negedge clk);
    d1_valid = 1'b0;
    check("n1_b_valid", {31'd0, d1_out_valid}, 32'd1);
    check("n1_b_ch0", {28'd0, d1_out[0]}, 32'd3);
    check("n1_b_ch1", {28'd0, d1_out[1]}, 32'd9);
    check("n1_b_sat", {31'd0, d1_sat}, 32'd0);
    @(negedge clk);
    check("n1_idle_valid", {31'd0, d1_out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
